bin2bcd_seq: RTL and testbench
==============================

# bin2bcd_seq

Parametrised, iterative binary-to-BCD converter (shift-and-add-3, "double dabble") with sign-magnitude output and valid/ready handshakes on both sides. It accepts one signed or unsigned binary word, converts it over `BIN_W` clock cycles, and presents packed BCD digits plus a sign bit. It sits between arithmetic datapaths and display/UART formatting logic, and generalises the fixed 11-bit signed pre-stage/converter pair to any width, digit count and signedness.

## Interface
- `BIN_W`, default 11: input word width; legal range 2..32.
- `DIGITS`, default 4: number of BCD output digits; must be ≥ decimal digits of 2^BIN_W−1 (unsigned) or 2^(BIN_W−1) (signed), otherwise elaboration fails via a package function check.
- `SIGNED`, default 1: 1 = `bin` is two's complement; 0 = `bin` is unsigned.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `bin_vld` in 1: input word valid.
- `bin_rdy` out 1: converter can accept a word.
- `bin` in BIN_W: binary input.
- `bcd_vld` out 1: result valid.
- `bcd_rdy` in 1: downstream accepts the result.
- `bcd` out 4*DIGITS: packed BCD, digit 0 (units) at [3:0].
- `bcd_sign` out 1: 1 = negative result.
- `busy` out 1: high in SHIFT.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: `bin_rdy`=1. On `bin_vld`&&`bin_rdy`: magnitude register ← |bin| computed in BIN_W unsigned bits (the most negative value converts exactly, e.g. −1024 → 1024); sign ← bin[BIN_W−1] if SIGNED, else 0; BCD accumulator ← 0; iteration counter ← 0; go to SHIFT.
- SHIFT: each cycle, for every digit ≥5 add 3 (4-bit, no carry out), then shift {accumulator, magnitude} left 1 with the magnitude MSB entering digit-0 LSB; counter +1. After BIN_W iterations go to DONE.
- DONE: `bcd_vld`=1; `bcd` and `bcd_sign` stay stable until `bcd_rdy`. On `bcd_rdy`: if `bin_vld` is also high, accept the new word in the same cycle and go to SHIFT (`bin_rdy` = `bcd_rdy` in DONE); otherwise go to IDLE.
- Zero input: `bcd_sign` = 0. Unsigned mode never sets the sign.
- `bin` is ignored outside accept cycles; the `bcd_rdy` level is ignored outside DONE.

## Timing
- Reset values: state IDLE, `bin_rdy`=1 (combinational from state), `bcd_vld`=0, `bcd`=0, `bcd_sign`=0, `busy`=0, counter 0.
- Latency: accept edge E0; iterations on edges E1..E_BIN_W; `bcd_vld` high from edge E_BIN_W (default: 11 cycles after accept).
- Throughput: one result per BIN_W+1 cycles with continuous `bcd_rdy`/`bin_vld` (back-to-back via DONE accept).
- `bcd`/`bcd_sign` are registered outputs and change only on entry to DONE or on reset.
- Reset asserted mid-SHIFT or in DONE: conversion discarded, all outputs return to reset values immediately (asynchronous). Conversion resumes only on a fresh accept after `rst_n` is released.

## Structure
- Package `bin2bcd_pkg`: state enum `bcd_state_t`; function `bcd_digits_needed(bin_w, signed_mode)` used for the DIGITS legality check; function `add3(nibble)`.
- Sub-module `bcd_dabble_step`: purely combinational, parametrised by DIGITS. It takes the accumulator and incoming bit and returns the next accumulator. The top level holds the FSM, counter, magnitude/sign registers and handshakes.

## Test plan
- Defaults, `bin`=0 with `bcd_rdy`=1 → `bcd`=16'h0000, sign 0, `bcd_vld` exactly 11 cycles after accept.
- Defaults: 11'h400 (−1024) → 16'h1024, sign 1; 11'h3FF (1023) → 16'h1023, sign 0; 11'h7FF (−1) → 16'h0001, sign 1.
- SIGNED=0, BIN_W=11, DIGITS=4: 11'h7FF → 16'h2047, sign 0. BIN_W=16, DIGITS=5, SIGNED=0: 16'hFFFF → 20'h65535.
- Backpressure: hold `bcd_rdy`=0 for 20 cycles in DONE with `bin_vld`=1 and changing `bin` → outputs stable, `bin_rdy`=0, no accept. Release → old result handshakes and new word accepted in the same cycle.
- Back-to-back stream of 100 random words, `bcd_rdy`=1 → every result matches the reference model, period 12 cycles.
- Assert `rst_n` low at iteration 5 → outputs at reset values at once. After release, the next conversion is correct and unaffected by the aborted word.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

   // Converter phases: waiting for a word, iterating, holding a result.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } bcd_state_t;

   // Number of decimal digits required to print the largest magnitude a
   // word of the given width can carry. Signed words reach 2^(w-1) because
   // the most negative value converts to its exact magnitude.
   function automatic int bcd_digits_needed(input int bin_w, input int signed_mode);
      longint unsigned maxVal;
      int              digitCount;
      if (signed_mode != 0) begin
         maxVal = 64'd1 << (bin_w - 1);
      end else begin
         maxVal = (64'd1 << bin_w) - 64'd1;
      end
      digitCount = 1;
      while (maxVal >= 64'd10) begin
         maxVal     = maxVal / 64'd10;
         digitCount = digitCount + 1;
      end
      return digitCount;
   endfunction

   // Double-dabble correction: a digit of 5 or more would overflow past 9
   // after the next doubling, so bias it by 3 first. Carry-out cannot occur
   // because legal digits stay in 0..9 (max 9+3 = 12).
   function automatic logic [3:0] add3(input logic [3:0] nibble);
      return (nibble >= 4'd5) ? (nibble + 4'd3) : nibble;
   endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One combinational shift-and-add-3 iteration over a packed BCD accumulator.
module bcd_dabble_step
   import bin2bcd_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic [4*DIGITS-1:0] acc_i,
   input  logic                bit_i,
   output logic [4*DIGITS-1:0] acc_o
);

   logic [4*DIGITS-1:0] adjusted;

   for (genvar g = 0; g < DIGITS; g++) begin : gDigit
      assign adjusted[4*g +: 4] = add3(acc_i[4*g +: 4]);
   end

   // The top digit's MSB falls off: with a legal DIGITS it is always zero.
   assign acc_o = {adjusted[4*DIGITS-2:0], bit_i};

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter with sign-magnitude output and
// valid/ready handshakes on the input and output sides.
module bin2bcd_seq
   import bin2bcd_pkg::*;
#(
   parameter int BIN_W  = 11,
   parameter int DIGITS = 4,
   parameter int SIGNED = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                bin_vld,
   output logic                bin_rdy,
   input  logic [BIN_W-1:0]    bin,
   output logic                bcd_vld,
   input  logic                bcd_rdy,
   output logic [4*DIGITS-1:0] bcd,
   output logic                bcd_sign,
   output logic                busy
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

   // Refuse to build configurations that cannot represent every result.
   if (BIN_W < 2 || BIN_W > 32) begin : gBadWidth
      $error("bin2bcd_seq: BIN_W=%0d outside 2..32", BIN_W);
   end
   if (DIGITS < bcd_digits_needed(BIN_W, SIGNED)) begin : gBadDigits
      $error("bin2bcd_seq: DIGITS=%0d too small, need %0d",
             DIGITS, bcd_digits_needed(BIN_W, SIGNED));
   end

   bcd_state_t          state_q;
   logic [BIN_W-1:0]    mag_q;
   logic [BCD_W-1:0]    acc_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                sign_q;
   logic [BCD_W-1:0]    bcd_q;
   logic                bcdSign_q;
   logic                bcdVld_q;
   logic                busy_q;

   logic                accept;
   logic                binNeg;
   logic [BIN_W-1:0]    binMag;
   logic [BCD_W-1:0]    accNext;

   // Ready in IDLE, or in DONE exactly when the held result is being taken,
   // which lets a new word enter on the same edge the old one leaves.
   assign bin_rdy = (state_q == IDLE) || ((state_q == DONE) && bcd_rdy);
   assign accept  = bin_vld && bin_rdy;

   // Magnitude in BIN_W unsigned bits: negating the most negative value
   // wraps to itself, which read unsigned is exactly its magnitude.
   assign binNeg = (SIGNED != 0) && bin[BIN_W-1];
   assign binMag = binNeg ? (~bin + {{(BIN_W-1){1'b0}}, 1'b1}) : bin;

   bcd_dabble_step #(
      .DIGITS (DIGITS)
   ) uStep (
      .acc_i (acc_q),
      .bit_i (mag_q[BIN_W-1]),
      .acc_o (accNext)
   );

   // Controller: sequences accept, BIN_W iterations and the result hold.
   // A word accepted in IDLE or DONE overrides the per-state transition.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         mag_q     <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         sign_q    <= 1'b0;
         bcd_q     <= '0;
         bcdSign_q <= 1'b0;
         bcdVld_q  <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_q <= IDLE;
            end
            SHIFT: begin
               acc_q <= accNext;
               mag_q <= {mag_q[BIN_W-2:0], 1'b0};
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST_ITER) begin
                  state_q   <= DONE;
                  bcd_q     <= accNext;
                  bcdSign_q <= sign_q;
                  bcdVld_q  <= 1'b1;
                  busy_q    <= 1'b0;
               end
            end
            DONE: begin
               if (bcd_rdy) begin
                  bcdVld_q <= 1'b0;
                  state_q  <= IDLE;
               end
            end
            default: begin
               state_q  <= IDLE;
               bcdVld_q <= 1'b0;
               busy_q   <= 1'b0;
            end
         endcase

         if (accept) begin
            state_q <= SHIFT;
            mag_q   <= binMag;
            sign_q  <= binNeg;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
         end
      end
   end

   assign bcd      = bcd_q;
   assign bcd_sign = bcdSign_q;
   assign bcd_vld  = bcdVld_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed and streamed checks of bin2bcd_seq in signed 11-bit, unsigned
// 11-bit and unsigned 16-bit configurations.
`timescale 1ns/1ps
module tb_bin2bcd_seq;

   logic        clk;
   logic        rst_n;

   logic        binVld, binRdy, bcdVld, bcdRdy, bcdSign, busy;
   logic [10:0] bin;
   logic [15:0] bcd;

   logic        u11Vld, u11BinRdy, u11BcdVld, u11BcdRdy, u11Sign, u11Busy;
   logic [10:0] u11Bin;
   logic [15:0] u11Bcd;

   logic        u16Vld, u16BinRdy, u16BcdVld, u16BcdRdy, u16Sign, u16Busy;
   logic [15:0] u16Bin;
   logic [19:0] u16Bcd;

   int errCount   = 0;
   int checkCount = 0;

   bin2bcd_seq dut (
      .clk(clk), .rst_n(rst_n), .bin_vld(binVld), .bin_rdy(binRdy), .bin(bin),
      .bcd_vld(bcdVld), .bcd_rdy(bcdRdy), .bcd(bcd), .bcd_sign(bcdSign), .busy(busy)
   );

   bin2bcd_seq #(.BIN_W(11), .DIGITS(4), .SIGNED(0)) dutU11 (
      .clk(clk), .rst_n(rst_n), .bin_vld(u11Vld), .bin_rdy(u11BinRdy), .bin(u11Bin),
      .bcd_vld(u11BcdVld), .bcd_rdy(u11BcdRdy), .bcd(u11Bcd), .bcd_sign(u11Sign),
      .busy(u11Busy)
   );

   bin2bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED(0)) dutU16 (
      .clk(clk), .rst_n(rst_n), .bin_vld(u16Vld), .bin_rdy(u16BinRdy), .bin(u16Bin),
      .bcd_vld(u16BcdVld), .bcd_rdy(u16BcdRdy), .bcd(u16Bcd), .bcd_sign(u16Sign),
      .busy(u16Busy)
   );

   // Free-running 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety net so a stuck handshake can never hang the run.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Independent decimal reference for the signed 11-bit configuration.
   function automatic logic [16:0] refSigned(input logic [10:0] b);
      int m;
      logic [15:0] r;
      m = int'(b);
      if (b[10]) m = 2048 - m;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'(m % 10);
         m = m / 10;
      end
      return {b[10], r};
   endfunction

   task automatic waitResult(input logic which, output int n);
      n = 0;
      while (!(which ? u16BcdVld : bcdVld) && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   // Caller is 1 ns after an edge with the default DUT idle.
   task automatic applyStimulus(input string tag, input logic [10:0] v,
                                input logic [15:0] expBcd, input logic expSign);
      int n;
      bin = v; binVld = 1'b1; bcdRdy = 1'b1;
      #1;
      checkOutput({tag, "_rdy"}, 32'(binRdy), 32'd1);
      @(posedge clk); #1;
      binVld = 1'b0; bin = 11'h2AA;
      checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
      waitResult(1'b0, n);
      checkOutput({tag, "_lat"}, 32'(n), 32'd11);
      checkOutput({tag, "_bcd"}, 32'(bcd), 32'(expBcd));
      checkOutput({tag, "_sign"}, 32'(bcdSign), 32'(expSign));
      @(posedge clk); #1;
      checkOutput({tag, "_vldoff"}, 32'(bcdVld), 32'd0);
   endtask

   task automatic applyUnsigned11(input string tag, input logic [10:0] v,
                                  input logic [15:0] expBcd);
      int n;
      u11Bin = v; u11Vld = 1'b1; u11BcdRdy = 1'b1;
      @(posedge clk); #1;
      u11Vld = 1'b0;
      n = 0;
      while (!u11BcdVld && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput({tag, "_lat"}, 32'(n), 32'd11);
      checkOutput({tag, "_bcd"}, 32'(u11Bcd), 32'(expBcd));
      checkOutput({tag, "_sign"}, 32'(u11Sign), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic applyUnsigned16(input string tag, input logic [15:0] v,
                                  input logic [19:0] expBcd);
      int n;
      u16Bin = v; u16Vld = 1'b1; u16BcdRdy = 1'b1;
      @(posedge clk); #1;
      u16Vld = 1'b0;
      waitResult(1'b1, n);
      checkOutput({tag, "_lat"}, 32'(n), 32'd16);
      checkOutput({tag, "_bcd"}, 32'(u16Bcd), 32'(expBcd));
      checkOutput({tag, "_sign"}, 32'(u16Sign), 32'd0);
      @(posedge clk); #1;
   endtask

   logic [10:0] vecBin  [8] = '{11'h000, 11'h400, 11'h3FF, 11'h7FF,
                                11'h001, 11'h07B, 11'h785, 11'h3E7};
   logic [15:0] vecBcd  [8] = '{16'h0000, 16'h1024, 16'h1023, 16'h0001,
                                16'h0001, 16'h0123, 16'h0123, 16'h0999};
   logic        vecSign [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

   initial begin
      int n, sent, got, cyc, lastHs;
      logic doAccept, doHs;
      logic [16:0] expQ[$];
      logic [16:0] expItem;

      rst_n = 1'b0;
      binVld = 1'b0; bcdRdy = 1'b0; bin = '0;
      u11Vld = 1'b0; u11BcdRdy = 1'b0; u11Bin = '0;
      u16Vld = 1'b0; u16BcdRdy = 1'b0; u16Bin = '0;
      #3;
      checkOutput("rst_binRdy", 32'(binRdy), 32'd1);
      checkOutput("rst_bcdVld", 32'(bcdVld), 32'd0);
      checkOutput("rst_bcd", 32'(bcd), 32'd0);
      checkOutput("rst_sign", 32'(bcdSign), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed signed vectors, including zero and the extremes.
      for (int i = 0; i < 8; i++) begin
         applyStimulus($sformatf("vec%0d", i), vecBin[i], vecBcd[i], vecSign[i]);
      end

      // Unsigned configurations never report a sign.
      applyUnsigned11("u11_max", 11'h7FF, 16'h2047);
      applyUnsigned11("u11_msb", 11'h400, 16'h1024);
      applyUnsigned11("u11_zero", 11'h000, 16'h0000);
      applyUnsigned16("u16_max", 16'hFFFF, 20'h65535);
      applyUnsigned16("u16_mid", 16'h3039, 20'h12345);

      // Backpressure: result must hold while a new word waits.
      bin = 11'h22B; binVld = 1'b1; bcdRdy = 1'b0;
      @(posedge clk); #1;
      waitResult(1'b0, n);
      checkOutput("bp_lat", 32'(n), 32'd11);
      checkOutput("bp_bcd0", 32'(bcd), 32'h0555);
      for (int i = 0; i < 20; i++) begin
         bin = 11'(i * 97 + 3);
         @(posedge clk); #1;
         checkOutput("bp_hold_bcd", 32'(bcd), 32'h0555);
         checkOutput("bp_hold_vld", 32'(bcdVld), 32'd1);
         checkOutput("bp_hold_rdy", 32'(binRdy), 32'd0);
         checkOutput("bp_hold_sign", 32'(bcdSign), 32'd0);
      end
      bin = 11'h785; bcdRdy = 1'b1;
      #1;
      checkOutput("bp_rel_rdy", 32'(binRdy), 32'd1);
      @(posedge clk); #1;
      binVld = 1'b0;
      checkOutput("bp_rel_vld", 32'(bcdVld), 32'd0);
      checkOutput("bp_rel_busy", 32'(busy), 32'd1);
      waitResult(1'b0, n);
      checkOutput("bp_new_lat", 32'(n), 32'd11);
      checkOutput("bp_new_bcd", 32'(bcd), 32'h0123);
      checkOutput("bp_new_sign", 32'(bcdSign), 32'd1);
      @(posedge clk); #1;

      // Back-to-back stream of random words against the decimal model.
      sent = 0; got = 0; cyc = 0; lastHs = -1;
      bin = 11'($urandom_range(0, 2047)); binVld = 1'b1; bcdRdy = 1'b1;
      while (got < 100 && cyc < 3000) begin
         doAccept = binRdy && binVld;
         doHs     = bcdVld && bcdRdy;
         if (doHs) begin
            if (expQ.size() == 0) begin
               checkOutput("stream_unexpected", 32'(bcd), 32'hDEAD);
            end else begin
               expItem = expQ.pop_front();
               checkOutput("stream_bcd", 32'(bcd), 32'(expItem[15:0]));
               checkOutput("stream_sign", 32'(bcdSign), 32'(expItem[16]));
            end
            if (lastHs >= 0) checkOutput("stream_period", 32'(cyc - lastHs), 32'd12);
            lastHs = cyc;
            got++;
         end
         if (doAccept) begin
            expQ.push_back(refSigned(bin));
            sent++;
         end
         @(posedge clk); #1;
         cyc++;
         if (doAccept) begin
            if (sent < 100) bin = 11'($urandom_range(0, 2047));
            else binVld = 1'b0;
         end
      end
      checkOutput("stream_count", 32'(got), 32'd100);
      @(posedge clk); #1;

      // Reset in the middle of a conversion aborts it immediately.
      bin = 11'h3FF; binVld = 1'b1; bcdRdy = 1'b1;
      @(posedge clk); #1;
      binVld = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("abort_busy_pre", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_vld", 32'(bcdVld), 32'd0);
      checkOutput("abort_rdy", 32'(binRdy), 32'd1);
      checkOutput("abort_bcd", 32'(bcd), 32'd0);
      checkOutput("abort_sign", 32'(bcdSign), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checkOutput("abort_noresume", 32'(busy), 32'd0);
      applyStimulus("after_abort", 11'h07B, 16'h0123, 1'b0);

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
